// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle MIPS-subset control unit, one state per cycle, Moore outputs (IF/memory states gated by MIO_ready).
// Ports: clk, rst (async, active-high); Inst_in (IR: op [31:26], funct [5:0]), MIO_ready, zero, overflow in;
//        memory strobes (MemRead, MemWrite, IorD), IR/PC loads (IRWrite, PCWrite, PCWriteCond, Branch, PCSource),
//        ALU operand/op selects (ALUSrc_A, ALUSrc_B, ALU_Control), write-back controls (RegDst, RegWrite,
//        DatatoReg, Jal) and state_out (debug) out.
// Config: define OVERFLOW_TRAP_EN to suppress write-back of add/sub/addi on signed overflow and add the ov_trap output.
module ctrl_mc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst_in,
    input  logic        MIO_ready,
    input  logic        zero,
    input  logic        overflow,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  Branch,
    output logic [1:0]  PCSource,
    output logic        ALUSrc_A,
    output logic [1:0]  ALUSrc_B,
    output logic [2:0]  ALU_Control,
    output logic        RegDst,
    output logic        RegWrite,
    output logic [1:0]  DatatoReg,
    output logic        Jal,
`ifdef OVERFLOW_TRAP_EN
    output logic        ov_trap,
`endif
    output logic [4:0]  state_out
);
    typedef enum logic [4:0] {
        S_IF = 5'd0, S_ID, S_MEM_ADR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_R_EXE,
        S_R_WB, S_BEQ, S_BNE, S_J, S_JAL, S_I_EXE, S_I_WB
    } state_t;
    state_t state_q, state_d;
    logic [5:0] op, fn;
    logic [2:0] r_alu, i_alu;
    logic r_known, ov_hit;
    assign op = Inst_in[31:26];
    assign fn = Inst_in[5:0];
    assign state_out = state_q;
    assign r_alu = fn == 6'b100010 ? 3'b110 :
                   fn == 6'b100100 ? 3'b000 :
                   fn == 6'b100101 ? 3'b001 :
                   fn == 6'b101010 ? 3'b111 :
                   fn == 6'b100111 ? 3'b100 : 3'b010;
    assign r_known = fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    assign i_alu = op == 6'b001010 ? 3'b111 : 3'b010;
`ifdef OVERFLOW_TRAP_EN
    // Only the signed arithmetic ops (add, sub, addi) trap; slt/slti/logic ops ignore the flag.
    assign ov_hit = overflow && ((state_q == S_R_WB && (fn == 6'b100000 || fn == 6'b100010)) ||
                                 (state_q == S_I_WB && op == 6'b001000));
    assign ov_trap = ov_hit && !rst;
    logic unused_bits;
    assign unused_bits = ^{Inst_in[25:6], zero};
`else
    assign ov_hit = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{Inst_in[25:6], zero, overflow};
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d     = S_IF;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        Branch      = 2'b00;
        PCSource    = 2'b00;
        ALUSrc_A    = 1'b0;
        ALUSrc_B    = 2'b00;
        ALU_Control = 3'b000;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        DatatoReg   = 2'b00;
        Jal         = 1'b0;
        // Outputs stay all-zero for the whole reset assertion, not just after the state register clears.
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    MemRead     = 1'b1;
                    ALUSrc_B    = 2'b01;
                    ALU_Control = 3'b010;
                    IRWrite     = MIO_ready;
                    PCWrite     = MIO_ready;
                    state_d     = MIO_ready ? S_ID : S_IF;
                end
                S_ID: begin
                    ALUSrc_B    = 2'b11;
                    ALU_Control = 3'b010;
                    case (op)
                        6'b000000:            state_d = S_R_EXE;
                        6'b100011, 6'b101011: state_d = S_MEM_ADR;
                        6'b000100:            state_d = S_BEQ;
                        6'b000101:            state_d = S_BNE;
                        6'b000010:            state_d = S_J;
                        6'b000011:            state_d = S_JAL;
                        6'b001000, 6'b001010: state_d = S_I_EXE;
                        default:              state_d = S_IF;
                    endcase
                end
                S_MEM_ADR: begin
                    ALUSrc_A    = 1'b1;
                    ALUSrc_B    = 2'b10;
                    ALU_Control = 3'b010;
                    state_d     = op == 6'b100011 ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = MIO_ready ? S_LW_WB : S_MEM_RD;
                end
                S_LW_WB: begin
                    DatatoReg = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    state_d  = MIO_ready ? S_IF : S_MEM_WR;
                end
                S_R_EXE: begin
                    ALUSrc_A    = 1'b1;
                    ALU_Control = r_alu;
                    state_d     = r_known ? S_R_WB : S_IF;
                end
                S_R_WB: begin
                    RegDst      = 1'b1;
                    RegWrite    = !ov_hit;
                    ALU_Control = r_alu;
                end
                S_BEQ, S_BNE: begin
                    ALUSrc_A    = 1'b1;
                    ALU_Control = 3'b110;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    Branch      = state_q == S_BEQ ? 2'b01 : 2'b10;
                end
                S_J: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_JAL: begin
                    PCWrite   = 1'b1;
                    PCSource  = 2'b10;
                    RegWrite  = 1'b1;
                    Jal       = 1'b1;
                    DatatoReg = 2'b10;
                end
                S_I_EXE: begin
                    ALUSrc_A    = 1'b1;
                    ALUSrc_B    = 2'b10;
                    ALU_Control = i_alu;
                    state_d     = S_I_WB;
                end
                S_I_WB: begin
                    RegWrite    = !ov_hit;
                    ALU_Control = i_alu;
                end
                default: state_d = S_IF;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: randomized self-checking bench for ctrl_mc against a per-instruction state-path model.
module tb_ctrl_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] Inst_in = '0;
    logic        MIO_ready = 1'b0;
    logic        zero = 1'b0;
    logic        overflow = 1'b0;
    logic        MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0]  Branch, PCSource, ALUSrc_B, DatatoReg;
    logic        ALUSrc_A, RegDst, RegWrite, Jal;
    logic [2:0]  ALU_Control;
    logic [4:0]  state_out;
`ifdef OVERFLOW_TRAP_EN
    logic        ov_trap;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    logic [20:0] obs;
    logic [5:0] ops [12] = '{6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3, 6'd8, 6'd10, 6'd1, 6'd63};
    logic [5:0] fns [8]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd63};

    ctrl_mc dut (
        .clk(clk), .rst(rst), .Inst_in(Inst_in), .MIO_ready(MIO_ready), .zero(zero), .overflow(overflow),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .Branch(Branch), .PCSource(PCSource), .ALUSrc_A(ALUSrc_A),
        .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .RegDst(RegDst), .RegWrite(RegWrite),
        .DatatoReg(DatatoReg), .Jal(Jal),
`ifdef OVERFLOW_TRAP_EN
        .ov_trap(ov_trap),
`endif
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    assign obs = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, Branch, PCSource,
                  ALUSrc_A, ALUSrc_B, ALU_Control, RegDst, RegWrite, DatatoReg, Jal};

    function automatic bit fn_known(input logic [5:0] fn);
        return fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42 || fn == 6'd39;
    endfunction

    function automatic bit exp_trap(input int s, input logic [5:0] op, input logic [5:0] fn, input logic ov);
        return TRAP && ov && ((s == 7 && (fn == 6'd32 || fn == 6'd34)) || (s == 13 && op == 6'd8));
    endfunction

    // Output table per state, straight from the state descriptions; same bit order as obs.
    function automatic logic [20:0] exp_out(input int s, input logic [5:0] op, input logic [5:0] fn,
                                            input logic mio, input logic ov);
        logic mr, mw, iod, irw, pcw, pcc, asa, rd, rw, jl;
        logic [1:0] br, ps, asb, dr;
        logic [2:0] alu, ralu;
        {mr, mw, iod, irw, pcw, pcc, asa, rd, rw, jl, br, ps, asb, dr, alu} = '0;
        ralu = fn == 6'd34 ? 3'b110 : fn == 6'd36 ? 3'b000 : fn == 6'd37 ? 3'b001 :
               fn == 6'd42 ? 3'b111 : fn == 6'd39 ? 3'b100 : 3'b010;
        case (s)
            0:  begin mr = 1; asb = 2'b01; alu = 3'b010; irw = mio; pcw = mio; end
            1:  begin asb = 2'b11; alu = 3'b010; end
            2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
            3:  begin mr = 1; iod = 1; end
            4:  begin dr = 2'b01; rw = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; alu = ralu; end
            7:  begin rd = 1; alu = ralu; rw = !exp_trap(s, op, fn, ov); end
            8, 9: begin asa = 1; alu = 3'b110; pcc = 1; ps = 2'b01; br = s == 8 ? 2'b01 : 2'b10; end
            10: begin pcw = 1; ps = 2'b10; end
            11: begin pcw = 1; ps = 2'b10; rw = 1; jl = 1; dr = 2'b10; end
            12: begin asa = 1; asb = 2'b10; alu = op == 6'd10 ? 3'b111 : 3'b010; end
            13: begin alu = op == 6'd10 ? 3'b111 : 3'b010; rw = !exp_trap(s, op, fn, ov); end
            default: ;
        endcase
        return {mr, mw, iod, irw, pcw, pcc, br, ps, asa, asb, alu, rd, rw, dr, jl};
    endfunction

    task automatic check(input int es, input logic [5:0] op, input logic [5:0] fn, input logic mio, input logic ov);
        logic [20:0] e;
        e = exp_out(es, op, fn, mio, ov);
        checks++;
        assert (state_out === 5'(es)) else begin
            errors++;
            $error("FAIL state_out op=%0d fn=%0d obs=%0d exp=%0d", op, fn, state_out, es);
        end
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL outputs state=%0d op=%0d fn=%0d obs=%b exp=%b", es, op, fn, obs, e);
        end
`ifdef OVERFLOW_TRAP_EN
        checks++;
        assert (ov_trap === exp_trap(es, op, fn, ov)) else begin
            errors++;
            $error("FAIL ov_trap state=%0d obs=%b exp=%b", es, ov_trap, exp_trap(es, op, fn, ov));
        end
`endif
    endtask

    // Builds the expected state path of one instruction (w1 fetch waits, w2 memory waits), then
    // drives it cycle by cycle. Entered and left just after a falling edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int w1, input int w2, input bit ovf);
        int path[$];
        bit mq[$];
        logic [31:0] inst;
        int ms;
        for (int i = 0; i < w1; i++) begin path.push_back(0); mq.push_back(1'b0); end
        path.push_back(0); mq.push_back(1'b1);
        path.push_back(1); mq.push_back(1'($urandom));
        if (op == 6'd0) begin
            path.push_back(6); mq.push_back(1'($urandom));
            if (fn_known(fn)) begin path.push_back(7); mq.push_back(1'($urandom)); end
        end else if (op == 6'd35 || op == 6'd43) begin
            ms = op == 6'd35 ? 3 : 5;
            path.push_back(2); mq.push_back(1'($urandom));
            for (int i = 0; i < w2; i++) begin path.push_back(ms); mq.push_back(1'b0); end
            path.push_back(ms); mq.push_back(1'b1);
            if (op == 6'd35) begin path.push_back(4); mq.push_back(1'($urandom)); end
        end else if (op == 6'd4)  begin path.push_back(8);  mq.push_back(1'($urandom)); end
        else if (op == 6'd5)      begin path.push_back(9);  mq.push_back(1'($urandom)); end
        else if (op == 6'd2)      begin path.push_back(10); mq.push_back(1'($urandom)); end
        else if (op == 6'd3)      begin path.push_back(11); mq.push_back(1'($urandom)); end
        else if (op == 6'd8 || op == 6'd10) begin
            path.push_back(12); mq.push_back(1'($urandom));
            path.push_back(13); mq.push_back(1'($urandom));
        end
        inst = $urandom;
        inst[31:26] = op;
        inst[5:0] = fn;
        foreach (path[k]) begin
            Inst_in = inst;
            MIO_ready = mq[k];
            overflow = ovf ? 1'b1 : 1'($urandom);
            zero = 1'($urandom);
            #1;
            check(path[k], op, fn, mq[k], overflow);
            @(negedge clk);
        end
    endtask

    initial begin
        Inst_in = {6'd35, 26'd0};
        MIO_ready = 1'b1;
        overflow = 1'b1;
        #3;
        checks++;
        assert (obs === 21'd0 && state_out === 5'd0) else begin
            errors++;
            $error("FAIL reset_outputs obs=%b state=%0d exp=0", obs, state_out);
        end
        @(negedge clk);
        checks++;
        assert (obs === 21'd0 && state_out === 5'd0) else begin
            errors++;
            $error("FAIL reset_held obs=%b state=%0d exp=0", obs, state_out);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        MIO_ready = 1'b0;
        #1;
        check(3, 6'd35, 6'd0, 1'b0, overflow);
        #1 rst = 1'b1;
        #1;
        checks++;
        assert (state_out === 5'd0 && RegWrite === 1'b0 && obs === 21'd0) else begin
            errors++;
            $error("FAIL async_reset state=%0d RegWrite=%b obs=%b exp state=0 all 0", state_out, RegWrite, obs);
        end
        @(negedge clk);
        rst = 1'b0;
        run_instr(6'd0,  6'd32, 0, 0, 1'b0);
        run_instr(6'd35, 6'd0,  0, 3, 1'b0);
        run_instr(6'd5,  6'd0,  0, 0, 1'b0);
        run_instr(6'd3,  6'd0,  1, 0, 1'b0);
        run_instr(6'd8,  6'd0,  0, 0, 1'b1);
        run_instr(6'd0,  6'd34, 0, 0, 1'b1);
        run_instr(6'd10, 6'd0,  0, 0, 1'b1);
        run_instr(6'd43, 6'd0,  2, 2, 1'b0);
        run_instr(6'd4,  6'd0,  0, 0, 1'b0);
        run_instr(6'd2,  6'd0,  0, 0, 1'b0);
        run_instr(6'd0,  6'd63, 0, 0, 1'b0);
        run_instr(6'd9,  6'd0,  0, 0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            run_instr(ops[$urandom_range(11)], fns[$urandom_range(7)], $urandom_range(2), $urandom_range(3), 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
